// File: rtl/irq_pkg.sv
// Shared constants for the interrupt source conditioner and its controller.
// Also provides the byte-lane helper used by the 8-bit register bus.
package irq_pkg;

  localparam int IRQ_LINES = 32;

  // Conditioner register offsets (each register spans 4 byte lanes)
  localparam logic [7:0] IRQ_PEND = 8'h00;
  localparam logic [7:0] IRQ_MODE = 8'h04;
  localparam logic [7:0] IRQ_POL  = 8'h08;
  localparam logic [7:0] IRQ_RAW  = 8'h0C;
  localparam logic [7:0] IRQ_SET  = 8'h10;

  // Interrupt controller offsets on the same bus
  localparam logic [7:0] IRQ_STAT = 8'h00;
  localparam logic [7:0] IRQ_MASK = 8'h04;
  localparam logic [7:0] IRQ_EOI  = 8'h08;

  // 32-bit mask covering the byte lane selected by the low address bits
  function automatic logic [31:0] lane_mask(input logic [1:0] lane);
    return 32'h0000_00FF << {lane, 3'b000};
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous interrupt lines.
// Each bit is synchronised independently; no cross-bit coherence is implied.
module irq_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // NOTE: every flop in the chain is reset and updated with <= so all stages shift together.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_src.sv
// Interrupt source conditioner: synchronises raw lines, applies polarity and
// level/edge selection, latches edge events and drives the controller's irpts.
module irq_src import irq_pkg::*; #(
  parameter int NUM_IRQ     = IRQ_LINES,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_,
  inout  wire  [7:0]  data,
  input  logic [7:0]  addr,
  input  logic        cs_,
  input  logic        oe_,
  input  logic        we_,
  input  logic [31:0] irq_in,
  output logic [31:0] irpts
);

  // Lines at and above NUM_IRQ are tied off everywhere through this mask
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFFF >> (IRQ_LINES - NUM_IRQ);

  logic [31:0] s_raw, s, prev, pending, mode, pol;
  logic [31:0] lane, wdata, clr, set, act, ev, pend_next, rd_word;
  logic [7:0]  reg_off, rd_byte;
  logic        wr_en;

  irq_sync #(.WIDTH(IRQ_LINES), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_ (rst_),
    .d    (irq_in),
    .q    (s_raw)
  );

  assign s       = s_raw & LINE_MASK;
  assign reg_off = addr & 8'hFC;
  assign wr_en   = ~cs_ & ~we_;
  assign lane    = lane_mask(addr[1:0]);
  assign wdata   = {4{data}} & lane & LINE_MASK;
  assign clr     = (wr_en && reg_off == IRQ_PEND) ? wdata : '0;
  assign set     = (wr_en && reg_off == IRQ_SET)  ? wdata : '0;

  // Edges come from raw s/prev so a POL write cannot fabricate an event
  assign act = s ^ pol;
  assign ev  = (s & ~prev & ~pol) | (~s & prev & pol);

  // Edge lines: event and set are OR-ed after the clear, so an event beats a clear
  assign pend_next = LINE_MASK & ((mode & ((pending & ~clr) | ev | set)) | (~mode & act));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      prev    <= '0;
      pending <= '0;
      mode    <= '0;
      pol     <= '0;
    end else begin
      prev    <= s;
      pending <= pend_next;
      if (wr_en && reg_off == IRQ_MODE) mode <= (mode & ~lane) | wdata;
      if (wr_en && reg_off == IRQ_POL)  pol  <= (pol & ~lane) | wdata;
    end
  end

  // NOTE: rd_word gets a default before the case so no latch is inferred.
  always_comb begin
    rd_word = '0;
    case (reg_off)
      IRQ_PEND: rd_word = pending;
      IRQ_MODE: rd_word = mode;
      IRQ_POL:  rd_word = pol;
      IRQ_RAW:  rd_word = s;
      default:  rd_word = '0;
    endcase
    rd_byte = rd_word[{addr[1:0], 3'b000} +: 8];
  end

  assign data  = (~cs_ & ~oe_) ? rd_byte : 8'bzzzz_zzzz;
  assign irpts = pending;

endmodule

// File: tb/tb_irq_src.sv
// Scoreboard bench for irq_src: stimulus pushes expected values, a negedge
// monitor pops and compares whenever a bus read or irpts probe is presented.
module tb_irq_src;

  logic        clk = 1'b0;
  logic        rst_;
  wire  [7:0]  data;
  logic [7:0]  addr;
  logic        cs_, oe_, we_;
  logic [31:0] irq_in;
  logic [31:0] irpts;

  logic [7:0]  tb_data;
  logic        tb_drive;
  logic        probe;

  typedef enum logic {K_BUS, K_IRPT} kind_e;
  typedef struct {
    kind_e       kind;
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  assign data = tb_drive ? tb_data : 8'bzzzz_zzzz;

  always #5 clk = ~clk;

  irq_src dut (
    .clk    (clk),
    .rst_   (rst_),
    .data   (data),
    .addr   (addr),
    .cs_    (cs_),
    .oe_    (oe_),
    .we_    (we_),
    .irq_in (irq_in),
    .irpts  (irpts)
  );

  // Monitor: compares on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (probe) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow: probe with no expected entry");
      end else begin
        sb_t         e;
        logic [31:0] got;
        e   = sb_q.pop_front();
        got = (e.kind == K_IRPT) ? irpts : {24'h0, data};
        if (got !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) cyc();
  endtask

  task automatic push(input kind_e k, input string nm, input logic [31:0] e);
    sb_t item;
    item.kind = k;
    item.name = nm;
    item.exp  = e;
    sb_q.push_back(item);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
    addr = a; cs_ = 1'b0; oe_ = 1'b0;
    push(K_BUS, nm, {24'h0, e});
    probe = 1'b1;
    cyc();
    probe = 1'b0; cs_ = 1'b1; oe_ = 1'b1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; tb_data = d; tb_drive = 1'b1; cs_ = 1'b0; we_ = 1'b0;
    cyc();
    cs_ = 1'b1; we_ = 1'b1; tb_drive = 1'b0;
  endtask

  task automatic chk_irpts(input logic [31:0] e, input string nm);
    push(K_IRPT, nm, e);
    probe = 1'b1;
    cyc();
    probe = 1'b0;
  endtask

  task automatic chk_z();
    addr = 8'h00; cs_ = 1'b1; oe_ = 1'b0;
    push(K_BUS, "data_z_when_deselected", {24'h0, 8'bzzzz_zzzz});
    probe = 1'b1;
    cyc();
    probe = 1'b0; oe_ = 1'b1;
  endtask

  initial begin
    rst_ = 1'b0; cs_ = 1'b1; oe_ = 1'b1; we_ = 1'b1;
    addr = 8'h00; tb_data = 8'h00; tb_drive = 1'b0; probe = 1'b0;
    irq_in = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1 rst_ = 1'b1;

    // RAW stays 0 for two cycles after release even with all inputs high
    rd(8'h0C, 8'h00, "raw_first_cycle");
    rd(8'h0D, 8'h00, "raw_second_cycle");
    irq_in = '0;
    wait_cyc(6);
    for (int a = 0; a < 20; a++) rd(8'(a), 8'h00, $sformatf("reset_read_%02h", a));
    rd(8'h20, 8'h00, "unmapped_read");
    chk_z();

    // Level, active-high, line 3
    irq_in[3] = 1'b1;
    wait_cyc(2);
    chk_irpts(32'h0, "level_rise_not_yet");
    chk_irpts(32'h0000_0008, "level_rise_k2");
    rd(8'h0C, 8'h08, "raw_line3");
    irq_in[3] = 1'b0;
    wait_cyc(2);
    chk_irpts(32'h0000_0008, "level_fall_not_yet");
    chk_irpts(32'h0, "level_fall_k2");

    // Rising edge, line 9
    wr(8'h05, 8'h02);
    rd(8'h05, 8'h02, "mode_byte1_readback");
    irq_in[9] = 1'b1;
    cyc();
    irq_in[9] = 1'b0;
    wait_cyc(3);
    chk_irpts(32'h0000_0200, "edge9_latched");
    wait_cyc(3);
    chk_irpts(32'h0000_0200, "edge9_held");
    wr(8'h01, 8'h02);
    chk_irpts(32'h0, "edge9_cleared");
    irq_in[9] = 1'b1;
    cyc();
    irq_in[9] = 1'b0;
    wait_cyc(3);
    chk_irpts(32'h0000_0200, "edge9_relatched");
    wr(8'h01, 8'h02);
    chk_irpts(32'h0, "edge9_cleared_again");

    // Falling edge, line 17
    wr(8'h06, 8'h02);
    irq_in[17] = 1'b1;
    wait_cyc(4);
    chk_irpts(32'h0002_0000, "edge17_rising_latched");
    wr(8'h02, 8'h02);
    chk_irpts(32'h0, "edge17_cleared");
    wr(8'h0A, 8'h02);
    rd(8'h0A, 8'h02, "pol_byte2_readback");
    wait_cyc(3);
    chk_irpts(32'h0, "pol_write_no_spurious_edge");
    irq_in[17] = 1'b0;
    wait_cyc(4);
    chk_irpts(32'h0002_0000, "edge17_falling_latched");
    wr(8'h02, 8'h02);
    chk_irpts(32'h0, "edge17_falling_cleared");
    irq_in[17] = 1'b1;
    wait_cyc(4);
    chk_irpts(32'h0, "edge17_rise_ignored_when_falling");
    irq_in[17] = 1'b0;
    wait_cyc(2);
    wr(8'h02, 8'h02);
    chk_irpts(32'h0002_0000, "event_beats_clear");
    wr(8'h02, 8'h02);
    chk_irpts(32'h0, "edge17_final_clear");

    // SET on line 31 in edge then level mode
    wr(8'h07, 8'h80);
    wr(8'h13, 8'h80);
    chk_irpts(32'h8000_0000, "set_edge31");
    rd(8'h13, 8'h00, "set_reads_zero");
    wr(8'h03, 8'h80);
    chk_irpts(32'h0, "set_edge31_cleared");
    wr(8'h07, 8'h00);
    wr(8'h13, 8'h80);
    chk_irpts(32'h0, "set_ignored_level31");

    // Asynchronous reset with several pending bits
    wr(8'h07, 8'h80);
    wr(8'h13, 8'h80);
    wr(8'h11, 8'h02);
    irq_in[3] = 1'b1;
    wait_cyc(3);
    chk_irpts(32'h8000_0208, "pending_before_reset");
    rst_ = 1'b0;
    chk_irpts(32'h0, "async_reset_immediate");
    irq_in = '0;
    rst_ = 1'b1;
    rd(8'h05, 8'h00, "mode_byte1_after_reset");
    rd(8'h06, 8'h00, "mode_byte2_after_reset");
    rd(8'h07, 8'h00, "mode_byte3_after_reset");
    rd(8'h0A, 8'h00, "pol_byte2_after_reset");
    chk_irpts(32'h0, "irpts_after_reset");

    wait_cyc(2);
    if (sb_q.size() != 0) begin
      n_err += sb_q.size();
      $display("FAIL scoreboard_leftover: %0d entries never compared, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
